ifu_sram_responder: RTL

- Memory-side responder for the instruction-fetch read handshake: accepts a read request (valid, address, byte-lane size), waits a fixed latency, returns the addressed data.
- Holds the response until the fetch unit acknowledges it.
- Sits between the fetch unit and a word-organised SRAM model. It has a load/write port for program preload and self-modifying-code tests.

---
 rtl/ifu_sram_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/ifu_sram_responder.sv
// rtl/ifu_sram_responder.sv - fixed-latency SRAM read responder for instruction fetch
module ifu_sram_responder #(
    parameter int          LATENCY    = 2,
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        ack_i,
    input  logic [7:0]  r_size_i,
    input  logic [31:0] r_addr_i,
    output logic        ready_o,
    output logic [63:0] r_data_o,
    output logic        r_err_o,
    input  logic        ld_en_i,
    input  logic [31:0] ld_addr_i,
    input  logic [63:0] ld_data_i
);

    localparam int          WORDS    = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN     = 33'd8 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [63:0] mem [0:WORDS-1];

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] r_addr_q;
    logic [7:0]  r_size_q;

    logic [31:0] rd_off;
    logic        rd_in_range;
    logic [63:0] rd_word;
    logic [63:0] rd_shift;
    logic [63:0] rd_data;
    logic [31:0] ld_off;
    logic        ld_in_range;

    // Offset compare against the window size covers both range bounds in one unsigned test.
    always_comb begin
        rd_off      = r_addr_q - BASE_ADDR;
        rd_in_range = {1'b0, rd_off} < SPAN;
        rd_word     = mem[rd_off[DEPTH_LOG2+2:3]];
        rd_shift    = rd_word >> {r_addr_q[2:0], 3'b000};
        rd_data     = '0;
        for (int k = 0; k < 8; k++) begin
            rd_data[8*k +: 8] = r_size_q[k] ? rd_shift[8*k +: 8] : 8'h00;
        end
        if (!rd_in_range) begin
            rd_data = '0;
        end
    end

    always_comb begin
        ld_off      = ld_addr_i - BASE_ADDR;
        ld_in_range = {1'b0, ld_off} < SPAN;
    end

    // Preload port is independent of the FSM and of reset.
    always_ff @(posedge clk) begin
        if (ld_en_i && ld_in_range) begin
            mem[ld_off[DEPTH_LOG2+2:3]] <= ld_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            r_addr_q <= '0;
            r_size_q <= '0;
            ready_o  <= 1'b0;
            r_data_o <= '0;
            r_err_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_addr_q <= r_addr_i;
                        r_size_q <= r_size_i;
                        cnt      <= CNT_INIT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Memory is sampled here, so a same-edge ld write is not seen.
                    if (cnt == 4'd0) begin
                        state    <= S_RESP;
                        ready_o  <= 1'b1;
                        r_data_o <= rd_data;
                        r_err_o  <= !rd_in_range;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (ack_i) begin
                        state    <= S_IDLE;
                        ready_o  <= 1'b0;
                        r_data_o <= '0;
                        r_err_o  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
